// File: rtl/conv_ofmap_pkg.sv
// rtl/conv_ofmap_pkg.sv - shared types and helpers for the ofmap write request path
package conv_ofmap_pkg;

  typedef enum logic [1:0] {
    U8  = 2'd0,
    U16 = 2'd1,
    U32 = 2'd2,
    RSV = 2'd3
  } ofmap_dtype_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } ofmap_wr_state_e;

  // Element size as a shift amount; the reserved code is stored as 4-byte elements.
  function automatic logic [1:0] dtype_log2_bytes(input ofmap_dtype_e dt);
    case (dt)
      U8:      return 2'd0;
      U16:     return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/ofmap_stride_calc.sv
// rtl/ofmap_stride_calc.sv - registered row length and channel-plane stride for one layer
module ofmap_stride_calc
  import conv_ofmap_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [15:0]       w_m1,
  input  logic [15:0]       h_m1,
  input  logic [1:0]        dtype,
  output logic [LEN_W-1:0]  row_len,
  output logic [ADDR_W-1:0] row_bytes,
  output logic [ADDR_W-1:0] chn_stride
);

  logic [16:0]       w_cnt;
  logic [16:0]       h_cnt;
  logic [1:0]        sh;
  logic [ADDR_W-1:0] hw_prod;

  // Counts are stored minus one, so widen by a bit before adding one back.
  assign w_cnt   = {1'b0, w_m1} + 17'd1;
  assign h_cnt   = {1'b0, h_m1} + 17'd1;
  assign sh      = dtype_log2_bytes(ofmap_dtype_e'(dtype));
  // Working at address width keeps the product modulo 2^ADDR_W, matching the address wrap.
  assign hw_prod = ADDR_W'(h_cnt) * ADDR_W'(w_cnt);

  // Capture both strides in the single setup cycle; they stay fixed for the whole layer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_len    <= '0;
      row_bytes  <= '0;
      chn_stride <= '0;
    end else if (en) begin
      row_len    <= LEN_W'(w_cnt) << sh;
      row_bytes  <= ADDR_W'(w_cnt) << sh;
      chn_stride <= hw_prod << sh;
    end
  end

endmodule

// File: rtl/conv_ofmap_wr_req_gen.sv
// rtl/conv_ofmap_wr_req_gen.sv - per-row, per-channel ofmap write request generator
module conv_ofmap_wr_req_gen
  import conv_ofmap_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       ofmap_baseaddr,
  input  logic [15:0]       ofmap_w,
  input  logic [15:0]       ofmap_h,
  input  logic [15:0]       kernal_num_n,
  input  logic [1:0]        ofmap_data_type,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  output logic [LEN_W-1:0]  req_len,
  output logic              req_last,
  output logic              busy,
  output logic              done
);

  ofmap_wr_state_e   state;
  ofmap_wr_state_e   state_nxt;

  logic [15:0]       w_q;
  logic [15:0]       h_q;
  logic [15:0]       cn_q;
  logic [1:0]        dt_q;
  logic [15:0]       y_cnt;
  logic [15:0]       c_cnt;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] row_bytes;
  logic [ADDR_W-1:0] chn_stride;
  logic [LEN_W-1:0]  row_len;
  logic              hs;
  logic              row_wrap;
  logic              at_last;

  assign hs       = (state == REQ) && req_ready;
  assign row_wrap = (c_cnt == cn_q);
  assign at_last  = (y_cnt == h_q) && row_wrap;

  ofmap_stride_calc #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_stride_calc (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (state == SETUP),
    .w_m1       (w_q),
    .h_m1       (h_q),
    .dtype      (dt_q),
    .row_len    (row_len),
    .row_bytes  (row_bytes),
    .chn_stride (chn_stride)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start is only looked at in IDLE, so a stray pulse mid-layer is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = REQ;
      REQ:     if (hs && at_last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state and counters only, never req_ready.
  always_comb begin
    req_valid = (state == REQ);
    req_last  = (state == REQ) && at_last;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  assign req_addr = cur_addr;
  assign req_len  = row_len;

  // Layer parameters, loop counters and incremental addresses; channel inner, row outer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q      <= '0;
      h_q      <= '0;
      cn_q     <= '0;
      dt_q     <= '0;
      y_cnt    <= '0;
      c_cnt    <= '0;
      row_base <= '0;
      cur_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_q      <= ofmap_w;
            h_q      <= ofmap_h;
            cn_q     <= kernal_num_n;
            dt_q     <= ofmap_data_type;
            y_cnt    <= '0;
            c_cnt    <= '0;
            row_base <= ADDR_W'(ofmap_baseaddr);
            cur_addr <= ADDR_W'(ofmap_baseaddr);
          end
        end
        REQ: begin
          if (req_ready) begin
            if (row_wrap) begin
              c_cnt    <= '0;
              y_cnt    <= y_cnt + 16'd1;
              row_base <= row_base + row_bytes;
              cur_addr <= row_base + row_bytes;
            end else begin
              c_cnt    <= c_cnt + 16'd1;
              cur_addr <= cur_addr + chn_stride;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ofmap_wr_req_gen.sv
// tb/tb_conv_ofmap_wr_req_gen.sv - directed self-checking bench for conv_ofmap_wr_req_gen
module tb_conv_ofmap_wr_req_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] ofmap_baseaddr;
  logic [15:0] ofmap_w;
  logic [15:0] ofmap_h;
  logic [15:0] kernal_num_n;
  logic [1:0]  ofmap_data_type;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [19:0] req_len;
  logic        req_last;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] got_addr [16];
  logic [19:0] got_len  [16];
  logic        got_last [16];
  int          n_req;
  int          done_cyc;
  int          done_cnt;
  int          first_valid_cyc;
  int          last_hs_cyc;
  int          stab_viol;
  logic        busy_after;

  always #5 clk = ~clk;

  conv_ofmap_wr_req_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .ofmap_baseaddr  (ofmap_baseaddr),
    .ofmap_w         (ofmap_w),
    .ofmap_h         (ofmap_h),
    .kernal_num_n    (kernal_num_n),
    .ofmap_data_type (ofmap_data_type),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_len         (req_len),
    .req_last        (req_last),
    .busy            (busy),
    .done            (done)
  );

  task automatic set_layer(input logic [31:0] base, input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] c, input logic [1:0] dt);
    ofmap_baseaddr  = base;
    ofmap_w         = w;
    ofmap_h         = h;
    kernal_num_n    = c;
    ofmap_data_type = dt;
  endtask

  // Runs one layer from the current cycle (cycle 0 = start cycle), logging handshakes.
  task automatic collect(input bit do_start, input bit stall, input bit disturb,
                         input int stop_n, input int max_cyc);
    int          stall_left;
    bit          held;
    bit          r;
    logic [31:0] h_addr;
    logic [19:0] h_len;
    logic        h_last;
    n_req = 0; done_cyc = -1; done_cnt = 0; first_valid_cyc = -1; last_hs_cyc = -1;
    stab_viol = 0; busy_after = 1'bx; stall_left = 3; held = 0;
    h_addr = '0; h_len = '0; h_last = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      start = do_start && (cyc == 0);
      if (disturb && cyc == 3) begin
        start = 1'b1;
        set_layer(32'hDEAD_0000, 16'd7, 16'd5, 16'd3, 2'd0);
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (req_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (held && (req_valid !== 1'b1 || req_addr !== h_addr || req_len !== h_len || req_last !== h_last))
        stab_viol++;
      r = stall ? (stall_left == 0) : 1'b1;
      if (!r) stall_left--;
      req_ready = r;
      if (req_valid === 1'b1 && r) begin
        if (n_req < 16) begin
          got_addr[n_req] = req_addr;
          got_len[n_req]  = req_len;
          got_last[n_req] = req_last;
        end
        n_req++;
        last_hs_cyc = cyc;
        held = 0;
        stall_left = 3 + int'($urandom_range(0, 2));
        if (stop_n > 0 && n_req == stop_n) begin
          @(posedge clk); #1;
          req_ready = 1'b0;
          start = 1'b0;
          return;
        end
      end else if (req_valid === 1'b1) begin
        held = 1; h_addr = req_addr; h_len = req_len; h_last = req_last;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    req_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; req_ready = 1'b0;
    set_layer(32'h0, 16'd0, 16'd0, 16'd0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_valid, req_last, busy, done} !== 4'b0) begin
      $display("FAIL reset_flags got %b exp 0000", {req_valid, req_last, busy, done}); n_fail++;
    end
    n_cmp++;
    if (req_addr !== 32'h0 || req_len !== 20'h0) begin
      $display("FAIL reset_addr_len got %h/%h exp 0/0", req_addr, req_len); n_fail++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] ea [4];
    logic        el [4];
    ea = '{32'h1000, 32'h100C, 32'h1006, 32'h1012};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_layer(32'h1000, 16'd2, 16'd1, 16'd1, 2'd1);
    collect(1, 0, 0, 0, 100);
    n_cmp++;
    if (n_req !== 4) begin $display("FAIL basic_count got %0d exp 4", n_req); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_addr[i] !== ea[i] || got_len[i] !== 20'd6 || got_last[i] !== el[i]) begin
        $display("FAIL basic_req%0d got %h/%0d/%b exp %h/6/%b", i, got_addr[i], got_len[i], got_last[i], ea[i], el[i]);
        n_fail++;
      end
    end
    n_cmp++;
    if (first_valid_cyc !== 2) begin $display("FAIL basic_first_valid got %0d exp 2", first_valid_cyc); n_fail++; end
    n_cmp++;
    if (last_hs_cyc !== 5) begin $display("FAIL back_to_back_last_hs got %0d exp 5", last_hs_cyc); n_fail++; end
    n_cmp++;
    if (done_cyc !== 6 || done_cnt !== 1) begin
      $display("FAIL basic_done got cyc %0d cnt %0d exp cyc 6 cnt 1", done_cyc, done_cnt); n_fail++;
    end
    n_cmp++;
    if (busy_after !== 1'b0) begin $display("FAIL basic_busy_after got %b exp 0", busy_after); n_fail++; end
  endtask

  task automatic test_stall();
    logic [31:0] ea [4];
    ea = '{32'h1000, 32'h100C, 32'h1006, 32'h1012};
    set_layer(32'h1000, 16'd2, 16'd1, 16'd1, 2'd1);
    collect(1, 1, 0, 0, 300);
    n_cmp++;
    if (n_req !== 4) begin $display("FAIL stall_count got %0d exp 4", n_req); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_addr[i] !== ea[i] || got_len[i] !== 20'd6 || got_last[i] !== (i == 3)) begin
        $display("FAIL stall_req%0d got %h/%0d/%b exp %h/6/%b", i, got_addr[i], got_len[i], got_last[i], ea[i], (i == 3));
        n_fail++;
      end
    end
    n_cmp++;
    if (stab_viol !== 0) begin $display("FAIL stall_stable got %0d changes exp 0", stab_viol); n_fail++; end
    n_cmp++;
    if (done_cyc !== last_hs_cyc + 1 || done_cnt !== 1) begin
      $display("FAIL stall_done got cyc %0d cnt %0d exp cyc %0d cnt 1", done_cyc, done_cnt, last_hs_cyc + 1); n_fail++;
    end
  endtask

  task automatic test_single();
    set_layer(32'h20, 16'd0, 16'd0, 16'd0, 2'd2);
    collect(1, 0, 0, 0, 50);
    n_cmp++;
    if (n_req !== 1 || got_addr[0] !== 32'h20 || got_len[0] !== 20'd4 || got_last[0] !== 1'b1) begin
      $display("FAIL single_req got n %0d %h/%0d/%b exp n 1 20/4/1", n_req, got_addr[0], got_len[0], got_last[0]);
      n_fail++;
    end
    n_cmp++;
    if (first_valid_cyc !== 2 || done_cyc !== 3) begin
      $display("FAIL single_timing got valid %0d done %0d exp valid 2 done 3", first_valid_cyc, done_cyc); n_fail++;
    end
    n_cmp++;
    if (busy_after !== 1'b0) begin $display("FAIL single_busy_after got %b exp 0", busy_after); n_fail++; end
  endtask

  task automatic test_addr_wrap();
    set_layer(32'hFFFF_FFF0, 16'd3, 16'd0, 16'd1, 2'd2);
    collect(1, 0, 0, 0, 50);
    n_cmp++;
    if (n_req !== 2) begin $display("FAIL wrap_count got %0d exp 2", n_req); n_fail++; end
    n_cmp++;
    if (got_addr[0] !== 32'hFFFF_FFF0 || got_addr[1] !== 32'h0) begin
      $display("FAIL wrap_addr got %h %h exp fffffff0 00000000", got_addr[0], got_addr[1]); n_fail++;
    end
    n_cmp++;
    if (got_len[0] !== 20'd16 || got_len[1] !== 20'd16 || got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      $display("FAIL wrap_len_last got %0d/%b %0d/%b exp 16/0 16/1", got_len[0], got_last[0], got_len[1], got_last[1]);
      n_fail++;
    end
  endtask

  task automatic test_start_mid_layer();
    logic [31:0] ea [4];
    int          idle_viol;
    ea = '{32'h1000, 32'h100C, 32'h1006, 32'h1012};
    set_layer(32'h1000, 16'd2, 16'd1, 16'd1, 2'd1);
    collect(1, 0, 1, 0, 100);
    n_cmp++;
    if (n_req !== 4) begin $display("FAIL disturb_count got %0d exp 4", n_req); n_fail++; end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_addr[i] !== ea[i] || got_len[i] !== 20'd6 || got_last[i] !== (i == 3)) begin
        $display("FAIL disturb_req%0d got %h/%0d/%b exp %h/6/%b", i, got_addr[i], got_len[i], got_last[i], ea[i], (i == 3));
        n_fail++;
      end
    end
    idle_viol = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || req_valid !== 1'b0) idle_viol++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (idle_viol !== 0) begin $display("FAIL disturb_no_second_layer got %0d busy cycles exp 0", idle_viol); n_fail++; end
  endtask

  task automatic test_reset_mid_layer();
    logic [31:0] ea [4];
    int          late_done;
    ea = '{32'h1000, 32'h100C, 32'h1006, 32'h1012};
    set_layer(32'h1000, 16'd2, 16'd1, 16'd1, 2'd1);
    collect(1, 0, 0, 2, 100);
    n_cmp++;
    if (n_req !== 2) begin $display("FAIL rst_mid_count got %0d exp 2", n_req); n_fail++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({req_valid, req_last, busy, done} !== 4'b0 || req_addr !== 32'h0 || req_len !== 20'h0) begin
      $display("FAIL rst_mid_outputs got %b %h %h exp 0000 0 0", {req_valid, req_last, busy, done}, req_addr, req_len);
      n_fail++;
    end
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) late_done++;
    end
    n_cmp++;
    if (late_done !== 0) begin $display("FAIL rst_mid_no_done got %0d exp 0", late_done); n_fail++; end
    collect(1, 0, 0, 0, 100);
    n_cmp++;
    if (n_req !== 4 || done_cnt !== 1) begin
      $display("FAIL rst_replay_count got %0d done %0d exp 4 done 1", n_req, done_cnt); n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_addr[i] !== ea[i] || got_last[i] !== (i == 3)) begin
        $display("FAIL rst_replay_req%0d got %h/%b exp %h/%b", i, got_addr[i], got_last[i], ea[i], (i == 3));
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_addr_wrap();
    test_start_mid_layer();
    test_reset_mid_layer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
